// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq
// Converts NDIG packed BCD digits to an unsigned binary value, one digit per
// clock, most significant digit first (acc = acc*10 + digit).
//
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - asynchronous active-low reset
//   start   - conversion request, sampled only while idle
//   bcd_in  - packed digits, [4*NDIG-1 -: 4] is the MSD, [3:0] the units digit
//   busy    - high while a conversion is in progress
//   done    - one-cycle pulse when bin_out/err/ovf are updated
//   bin_out - converted value, held until the next done
//   err     - last conversion contained a digit greater than 9
//   ovf     - last (valid) conversion result exceeded LIMIT
module bcd_to_bin_seq #(
    parameter int NDIG  = 4,
    parameter int OUT_W = 14,
    parameter int LIMIT = 1023
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*NDIG-1:0]   bcd_in,
    output logic                busy,
    output logic                done,
    output logic [OUT_W-1:0]    bin_out,
    output logic                err,
    output logic                ovf
);

    localparam int                IDX_W    = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NDIG - 1);
    localparam logic [IDX_W-1:0]  IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [OUT_W-1:0]  LIMIT_V  = OUT_W'(LIMIT);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    // True when any packed digit lies outside 0..9.
    function automatic logic any_invalid(input logic [4*NDIG-1:0] digits);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            bad = bad | (digits[4*i +: 4] > 4'd9);
        end
        return bad;
    endfunction

    state_t               state_r;
    state_t               next_state_s;
    logic                 load_s;
    logic                 step_s;
    logic                 finish_s;

    logic [4*NDIG-1:0]    shreg_r;
    logic [OUT_W-1:0]     acc_r;
    logic [IDX_W-1:0]     idx_r;
    logic                 invalid_r;

    logic                 busy_r;
    logic                 done_r;
    logic [OUT_W-1:0]     bin_out_r;
    logic                 err_r;
    logic                 ovf_r;

    logic [3:0]           digit_s;
    logic [OUT_W-1:0]     acc_x10_s;
    logic [OUT_W-1:0]     new_acc_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and datapath control strobes.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s       = 1'b1;
                    next_state_s = ST_CONV;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                step_s = 1'b1;
                if (idx_r == IDX_ZERO) begin
                    finish_s     = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_CONV;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Multiply-accumulate step; the shift register always presents the
    // current digit at its top nibble, and *10 is built from two shifts.
    always_comb begin
        digit_s   = shreg_r[4*NDIG-1 -: 4];
        acc_x10_s = (acc_r << 3'd3) + (acc_r << 3'd1);
        new_acc_s = acc_x10_s + OUT_W'(digit_s);
    end

    // Conversion datapath: digit capture, accumulation and index count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r   <= {(4*NDIG){1'b0}};
            acc_r     <= {OUT_W{1'b0}};
            idx_r     <= IDX_ZERO;
            invalid_r <= 1'b0;
        end else if (load_s) begin
            shreg_r   <= bcd_in;
            acc_r     <= {OUT_W{1'b0}};
            idx_r     <= IDX_LAST;
            invalid_r <= any_invalid(bcd_in);
        end else if (step_s) begin
            shreg_r <= shreg_r << 3'd4;
            acc_r   <= new_acc_s;
            if (finish_s) begin
                idx_r <= idx_r;
            end else begin
                idx_r <= idx_r - 1'b1;
            end
        end else begin
            shreg_r   <= shreg_r;
            acc_r     <= acc_r;
            idx_r     <= idx_r;
            invalid_r <= invalid_r;
        end
    end

    // Registered handshake and result outputs; results change only at done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            bin_out_r <= {OUT_W{1'b0}};
            err_r     <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            busy_r <= (next_state_s == ST_CONV);
            done_r <= finish_s;
            if (finish_s) begin
                // An invalid digit forces a zero result and suppresses ovf.
                bin_out_r <= invalid_r ? {OUT_W{1'b0}} : new_acc_s;
                err_r     <= invalid_r;
                ovf_r     <= (!invalid_r) && (new_acc_s > LIMIT_V);
            end else begin
                bin_out_r <= bin_out_r;
                err_r     <= err_r;
                ovf_r     <= ovf_r;
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign bin_out = bin_out_r;
    assign err     = err_r;
    assign ovf     = ovf_r;

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
Sequential converter from packed BCD digits back to unsigned binary. It performs the inverse of the team's binary-to-BCD display path, for keypad or switch entry of decimal values. One digit is processed per clock, most significant digit first, using acc = acc*10 + digit. A start/busy/done handshake is provided, plus flags for an invalid digit and for a result above a limit.

Parameters:
NDIG, 4, number of BCD digits converted.
OUT_W, 14, binary result width; must satisfy 2^OUT_W > 10^NDIG - 1.
LIMIT, 1023, largest result accepted without raising ovf; default matches the 10-bit datapath range.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request conversion; sampled only while idle.
bcd_in  input  4*NDIG  packed digits; [4*NDIG-1:4*NDIG-4] is the MSD, [3:0] is the units digit.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when bin_out, err and ovf are updated.
bin_out  output  OUT_W  converted value; held until the next done.
err  output  1  last conversion saw a digit greater than 9.
ovf  output  1  last conversion result was greater than LIMIT.

Behaviour:
- Clocking and reset: one clock (clk); reset rst_n is asynchronous and active-low. While rst_n=0: state=IDLE, busy=0, done=0, bin_out=0, err=0, ovf=0, accumulator=0, digit index=0.
- FSM has two states, IDLE and CONV.
- IDLE: on a rising edge with start=1:
  - capture bcd_in into an internal shift register
  - clear the accumulator
  - latch a sticky invalid flag = OR over all digits of (digit > 9)
  - set index to NDIG-1, go to CONV, busy=1.
- IDLE with start=0: no change.
- CONV: each edge computes acc <= acc*10 + digit[index]. Use the same width throughout; *10 is implemented as (acc<<3)+(acc<<1), with no multiplier inferred.
- CONV, final edge (index==0):
  - bin_out <= invalid ? 0 : new acc
  - err <= invalid
  - ovf <= (!invalid && new acc > LIMIT)
  - done <= 1, busy <= 0, state <= IDLE.
- Otherwise in CONV, index decrements by 1.
- Latency: start sampled at edge k; done=1 and results valid after edge k+NDIG (4 cycles by default). done stays high exactly one cycle.
- A new start is accepted on the cycle done is high, since the FSM is already in IDLE. Back-to-back throughput is one conversion per NDIG+1 cycles minimum... correction: per NDIG cycles plus the start-sampling edge.
- start while busy=1 is ignored; there is no queueing. bcd_in changes while busy have no effect, because digits were captured at start.
- Invalid digits still take the full NDIG cycles, so latency is data-independent.
- err and ovf are not sticky across conversions; both are rewritten at every done.
- Reset mid-conversion: outputs return to their reset values immediately, no done is produced, and the aborted conversion is lost.
- The accumulator cannot wrap for valid inputs, given the OUT_W constraint.

Test Plan:
- Reset, then start with bcd_in=16'h0000 -> done at edge k+4, bin_out=0, err=0, ovf=0.
- bcd_in=16'h1023, start -> busy high 4 cycles, then bin_out=1023, ovf=0, err=0; check the done pulse width is 1 cycle.
- bcd_in=16'h9999 -> bin_out=9999 (14'h270F), ovf=1, err=0.
- bcd_in=16'h12A4 (invalid digit) -> bin_out=0, err=1, ovf=0, latency still 4 cycles. Follow with 16'h0042 -> bin_out=42, err=0.
- Re-assert start while busy, and change bcd_in to 16'h5555 mid-conversion -> both ignored, result = originally captured value. Then start on the done cycle -> second conversion accepted, with done 4 cycles later.
- Assert rst_n=0 at cycle 2 of a conversion of 16'h0777 -> busy=0, done never pulses, bin_out=0. After release, start with 16'h0777 -> bin_out=777.
